// File: rtl/sd_burst_responder.sv
// Block-RAM stand-in for the external SDRAM on the 16-bit sd_* burst interface.
// Models CAS latency before read data and periodic refresh windows taken only from IDLE.
module sd_burst_responder #(
    parameter int ADDR_WIDTH     = 12,
    parameter int CAS_LATENCY    = 2,
    parameter int REFRESH_PERIOD = 512,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_ce,
    input  logic [31:0] sd_address,
    input  logic        sd_rw_req,
    input  logic        sd_rw,
    input  logic [15:0] sd_write_data,
    input  logic [7:0]  sd_burst_len,
    output logic [15:0] sd_read_data,
    output logic        sd_data_bursting,
    output logic        busy
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int REF_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int RCYC_W = $clog2(REFRESH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LATENCY,
        RD_BURST,
        WR_BURST,
        DONE,
        REFRESH
    } state_t;

    logic [15:0]           mem [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            remaining;
    logic [2:0]            lat_cnt;
    logic [REF_W-1:0]      ref_cnt;
    logic                  ref_pending;
    logic [RCYC_W-1:0]     ref_timer;
    logic                  ref_wrap;
    logic                  mem_we;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{sd_address[31:ADDR_WIDTH+1], sd_address[0]};
    assign ref_wrap         = (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
    // A reset arriving mid-burst must suppress the write of the beat in flight.
    assign mem_we           = (state == WR_BURST) && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= sd_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            addr             <= '0;
            remaining        <= '0;
            lat_cnt          <= '0;
            ref_cnt          <= '0;
            ref_pending      <= 1'b0;
            ref_timer        <= '0;
            sd_read_data     <= '0;
            sd_data_bursting <= 1'b0;
            busy             <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (ref_pending) begin
                        state     <= REFRESH;
                        ref_timer <= RCYC_W'(REFRESH_CYCLES - 1);
                        busy      <= 1'b1;
                    end else if (sd_ce && sd_rw_req) begin
                        addr      <= sd_address[ADDR_WIDTH:1];
                        remaining <= (sd_burst_len == 8'd0) ? 8'd1 : sd_burst_len;
                        busy      <= 1'b1;
                        if (sd_rw) begin
                            state            <= WR_BURST;
                            sd_data_bursting <= 1'b1;
                        end else begin
                            state   <= LATENCY;
                            lat_cnt <= 3'(CAS_LATENCY - 1);
                        end
                    end
                end

                // The RAM read for beat 0 is issued on the last latency edge.
                LATENCY: begin
                    if (lat_cnt == 3'd0) begin
                        state            <= RD_BURST;
                        sd_data_bursting <= 1'b1;
                        sd_read_data     <= mem[addr];
                        addr             <= addr + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                RD_BURST: begin
                    if (remaining == 8'd1) begin
                        state            <= DONE;
                        sd_data_bursting <= 1'b0;
                    end else begin
                        sd_read_data <= mem[addr];
                        addr         <= addr + 1'b1;
                        remaining    <= remaining - 1'b1;
                    end
                end

                WR_BURST: begin
                    addr <= addr + 1'b1;
                    if (remaining == 8'd1) begin
                        state            <= DONE;
                        sd_data_bursting <= 1'b0;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end

                DONE: begin
                    if (!sd_rw_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                REFRESH: begin
                    if (ref_timer == '0) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        ref_pending <= 1'b0;
                    end else begin
                        ref_timer <= ref_timer - 1'b1;
                    end
                end

                default: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    sd_data_bursting <= 1'b0;
                end
            endcase

            // A wrap on the same edge that ends a refresh must not be lost.
            if (ref_wrap) begin
                ref_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_burst_responder.sv
// Directed bench for sd_burst_responder: read expectations go into a queue that a
// negedge monitor pops on every read beat; timing is checked with per-cycle traces.
module tb_sd_burst_responder;

    localparam int RP = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sd_ce = 1'b0;
    logic [31:0] sd_address = '0;
    logic        sd_rw_req = 1'b0;
    logic        sd_rw = 1'b0;
    logic [15:0] sd_write_data = '0;
    logic [7:0]  sd_burst_len = '0;
    logic [15:0] sd_read_data;
    logic        sd_data_bursting;
    logic        busy;

    int          assertions = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;
    bit          read_mode = 1'b0;
    logic [15:0] wr_data[8];
    logic [15:0] rd_exp[8];
    logic [15:0] busy_trace;
    logic [15:0] burst_trace;

    always #5 clk = ~clk;

    sd_burst_responder #(
        .ADDR_WIDTH    (12),
        .CAS_LATENCY   (2),
        .REFRESH_PERIOD(RP),
        .REFRESH_CYCLES(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sd_ce           (sd_ce),
        .sd_address      (sd_address),
        .sd_rw_req       (sd_rw_req),
        .sd_rw           (sd_rw),
        .sd_write_data   (sd_write_data),
        .sd_burst_len    (sd_burst_len),
        .sd_read_data    (sd_read_data),
        .sd_data_bursting(sd_data_bursting),
        .busy            (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        assertions++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Scoreboard monitor: every read beat must match the oldest queued word.
    always @(negedge clk) begin
        if (read_mode && sd_data_bursting === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected read beat", 32'd1, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("read data", {16'd0, sd_read_data}, {16'd0, exp_word});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetDut;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        sd_rw_req = 1'b0;
        sd_ce     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic rw);
        sd_address   = addr;
        sd_burst_len = len;
        sd_rw        = rw;
        sd_ce        = 1'b1;
        sd_rw_req    = 1'b1;
    endtask

    task automatic releaseAndIdle(input string name);
        sd_rw_req = 1'b0;
        sd_ce     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [7:0] len, input int abort_beat);
        int  beats;
        int  eff_len;
        bit  b;
        beats   = 0;
        eff_len = (len == 8'd0) ? 1 : int'(len);
        sd_write_data = wr_data[0];
        applyStimulus(addr, len, 1'b1);
        for (int cyc = 0; cyc < 40 && beats < eff_len; cyc++) begin
            @(negedge clk);
            b = sd_data_bursting;
            if (b && beats == abort_beat) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset     = 1'b0;
                sd_rw_req = 1'b0;
                sd_ce     = 1'b0;
                @(negedge clk);
                checkOutput("bursting after reset", {31'd0, sd_data_bursting}, 32'd0);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            if (b) begin
                beats++;
                if (beats < eff_len) sd_write_data = wr_data[beats];
            end
        end
        checkOutput("write beat count", beats, eff_len);
        @(negedge clk);
        checkOutput("write burst ended", {31'd0, sd_data_bursting}, 32'd0);
        releaseAndIdle("idle after write");
    endtask

    task automatic doRead(input logic [31:0] addr, input logic [7:0] len);
        int beats;
        int eff_len;
        beats   = 0;
        eff_len = (len == 8'd0) ? 1 : int'(len);
        for (int i = 0; i < eff_len; i++) exp_q.push_back(rd_exp[i]);
        read_mode = 1'b1;
        applyStimulus(addr, len, 1'b0);
        for (int cyc = 0; cyc < 40 && beats < eff_len; cyc++) begin
            @(negedge clk);
            if (sd_data_bursting) beats++;
        end
        checkOutput("read beat count", beats, eff_len);
        @(posedge clk);
        #1;
        releaseAndIdle("idle after read");
        read_mode = 1'b0;
    endtask

    // Holds the request for a fixed window and records busy/bursting per cycle (bit i = cycle i).
    task automatic traceRead(input logic [31:0] addr, input logic [7:0] len, input int cycles,
                             output logic [15:0] busy_t, output logic [15:0] burst_t);
        busy_t  = '0;
        burst_t = '0;
        for (int i = 0; i < int'(len); i++) exp_q.push_back(rd_exp[i]);
        read_mode = 1'b1;
        applyStimulus(addr, len, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            busy_t[i]  = busy;
            burst_t[i] = sd_data_bursting;
        end
        sd_rw_req = 1'b0;
        sd_ce     = 1'b0;
        @(negedge clk);
        checkOutput("busy after request drop", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        read_mode = 1'b0;
    endtask

    initial begin
        resetDut();
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset bursting", {31'd0, sd_data_bursting}, 32'd0);
        checkOutput("reset read data", {16'd0, sd_read_data}, 32'd0);

        // Memory survives reset: write before, read after.
        wr_data[0] = 16'hBEEF;
        doWrite(32'h20, 8'd1, -1);
        resetDut();
        checkOutput("reset busy again", {31'd0, busy}, 32'd0);
        rd_exp[0] = 16'hBEEF;
        traceRead(32'h20, 8'd1, 6, busy_trace, burst_trace);
        checkOutput("single read busy trace", {16'd0, busy_trace}, 32'h3E);
        checkOutput("single read beat trace", {16'd0, burst_trace}, 32'h08);

        wr_data[0] = 16'h1111; wr_data[1] = 16'h2222; wr_data[2] = 16'h3333; wr_data[3] = 16'h4444;
        doWrite(32'h100, 8'd4, -1);
        rd_exp[0] = 16'h1111; rd_exp[1] = 16'h2222; rd_exp[2] = 16'h3333; rd_exp[3] = 16'h4444;
        doRead(32'h100, 8'd4);
        checkOutput("read data holds", {16'd0, sd_read_data}, 32'h4444);

        rd_exp[0] = 16'hBEEF;
        doRead(32'h20, 8'd0);

        wr_data[0] = 16'h5A01; wr_data[1] = 16'h5A02; wr_data[2] = 16'h5A03;
        doWrite(32'h1FFC, 8'd3, -1);
        rd_exp[0] = 16'h5A01; rd_exp[1] = 16'h5A02; rd_exp[2] = 16'h5A03;
        doRead(32'h1FFC, 8'd3);
        rd_exp[0] = 16'h5A03;
        doRead(32'h0000, 8'd1);
        rd_exp[0] = 16'h5A02;
        doRead(32'h1FFF, 8'd1);

        resetDut();
        rd_exp[0] = 16'h1111; rd_exp[1] = 16'h2222;
        traceRead(32'h100, 8'd2, 14, busy_trace, burst_trace);
        checkOutput("held request busy trace", {16'd0, busy_trace}, 32'h3FFE);
        checkOutput("held request beat trace", {16'd0, burst_trace}, 32'h0018);

        // The refresh counter wraps on the RP-th edge after reset, so the request lands with ref_pending.
        resetDut();
        repeat (RP) @(posedge clk);
        #1;
        rd_exp[0] = 16'hBEEF;
        traceRead(32'h20, 8'd1, 10, busy_trace, burst_trace);
        checkOutput("refresh collision busy trace", {16'd0, busy_trace}, 32'h3DE);
        checkOutput("refresh collision beat trace", {16'd0, burst_trace}, 32'h100);

        for (int i = 0; i < 8; i++) wr_data[i] = 16'hAAAA;
        doWrite(32'h200, 8'd8, -1);
        for (int i = 0; i < 8; i++) wr_data[i] = 16'hD000 + 16'(i);
        doWrite(32'h200, 8'd8, 3);
        rd_exp[0] = 16'hD000; rd_exp[1] = 16'hD001; rd_exp[2] = 16'hD002;
        for (int i = 3; i < 8; i++) rd_exp[i] = 16'hAAAA;
        doRead(32'h200, 8'd8);

        checkOutput("scoreboard drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
